// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: load-use interlock,
// mispredict squash, multi-cycle data memory handshake and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int PREG_WIDTH = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_rs_valid,
  input  logic                  id_rt_valid,
  input  logic [PREG_WIDTH-1:0] id_rs_addr,
  input  logic [PREG_WIDTH-1:0] id_rt_addr,
  input  logic                  ex_mem_enable,
  input  logic                  ex_mem_rw,
  input  logic                  ex_wb_reg,
  input  logic [PREG_WIDTH-1:0] ex_write_addr,
  input  logic                  branch_mispredict,
  input  logic                  mem_enable,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  flush_mem,
  output logic                  flush_wb,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  flush_events
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_mem_req;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;
  logic [CNT_WIDTH-1:0]  r_flush_events;
  logic                  w_mem_hold;
  logic                  w_rs_match;
  logic                  w_rt_match;
  logic                  w_load_use;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mem_req <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_mem_req <= (w_next_state == ST_WAIT);
    end
  end

  // DONE exists so the instruction still parked in MEM cannot re-request.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (mem_enable) w_next_state = ST_WAIT;
      ST_WAIT: if (mem_ack)    w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_hold = ((r_state == ST_IDLE) && mem_enable) || (r_state == ST_WAIT);
    w_rs_match = id_rs_valid && (id_rs_addr == ex_write_addr);
    w_rt_match = id_rt_valid && (id_rt_addr == ex_write_addr);
    w_load_use = ex_mem_enable && !ex_mem_rw && ex_wb_reg &&
                 (ex_write_addr != '0) && (w_rs_match || w_rt_match);
  end

  // Memory hold outranks the squash, which outranks the load-use bubble.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    if (w_mem_hold) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (branch_mispredict) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (w_load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (stall_mem && !(&r_stall_cycles))
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      if (flush_id && !(&r_flush_events))
        r_flush_events <= r_flush_events + CNT_WIDTH'(1);
    end
  end

  assign mem_req      = r_mem_req;
  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; counters narrowed to 4 bits so saturation
// is reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

  localparam int PW = 6;
  localparam int CW = 4;

  // Control vector order: req, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb
  localparam logic [8:0] NONE      = 9'b0_0000_0000;
  localparam logic [8:0] HOLD_IDLE = 9'b0_1111_0001;
  localparam logic [8:0] HOLD_WAIT = 9'b1_1111_0001;
  localparam logic [8:0] SQUASH    = 9'b0_0000_1100;
  localparam logic [8:0] LOADUSE   = 9'b0_1100_0100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_rs_valid, id_rt_valid;
  logic [PW-1:0] id_rs_addr, id_rt_addr;
  logic          ex_mem_enable, ex_mem_rw, ex_wb_reg;
  logic [PW-1:0] ex_write_addr;
  logic          branch_mispredict, mem_enable, mem_ack;
  logic          mem_req;
  logic          stall_if, stall_id, stall_ex, stall_mem;
  logic          flush_id, flush_ex, flush_mem, flush_wb;
  logic [CW-1:0] stall_cycles, flush_events;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic [8:0] ctl;
  assign ctl = {mem_req, stall_if, stall_id, stall_ex, stall_mem,
                flush_id, flush_ex, flush_mem, flush_wb};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.PREG_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .ex_mem_enable(ex_mem_enable), .ex_mem_rw(ex_mem_rw), .ex_wb_reg(ex_wb_reg),
    .ex_write_addr(ex_write_addr), .branch_mispredict(branch_mispredict),
    .mem_enable(mem_enable), .mem_ack(mem_ack), .mem_req(mem_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // Drives one cycle's inputs just after the falling edge and lets them settle.
  task automatic applyStimulus(input logic memEn, input logic ack, input logic misp,
                               input logic exMem, input logic exRw, input logic exWb,
                               input logic [PW-1:0] exAddr,
                               input logic rsV, input logic [PW-1:0] rsA,
                               input logic rtV, input logic [PW-1:0] rtA);
    @(negedge clk);
    mem_enable        = memEn;
    mem_ack           = ack;
    branch_mispredict = misp;
    ex_mem_enable     = exMem;
    ex_mem_rw         = exRw;
    ex_wb_reg         = exWb;
    ex_write_addr     = exAddr;
    id_rs_valid       = rsV;
    id_rs_addr        = rsA;
    id_rt_valid       = rtV;
    id_rt_addr        = rtA;
    #1;
  endtask

  task automatic idleStep(input logic memEn, input logic ack, input logic misp);
    applyStimulus(memEn, ack, misp, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idleStep(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idleStep(1'b0, 1'b0, 1'b0);
    checkOutput("reset_ctl", 32'(ctl), 32'(NONE));
    checkOutput("reset_stall_cnt", 32'(stall_cycles), 0);
    checkOutput("reset_flush_cnt", 32'(flush_events), 0);

    // Load in MEM, ack on third WAIT cycle
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("ld_idle_hold", 32'(ctl), 32'(HOLD_IDLE));
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("ld_wait1", 32'(ctl), 32'(HOLD_WAIT));
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("ld_wait2", 32'(ctl), 32'(HOLD_WAIT));
    idleStep(1'b1, 1'b1, 1'b0); checkOutput("ld_wait3_ack", 32'(ctl), 32'(HOLD_WAIT));
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("ld_done", 32'(ctl), 32'(NONE));
    checkOutput("ld_stall_cnt", 32'(stall_cycles), 4);
    idleStep(1'b0, 1'b0, 1'b0); checkOutput("ld_back_idle", 32'(ctl), 32'(NONE));

    // Load-use detection variants
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0);
    checkOutput("lu_rs_p5", 32'(ctl), 32'(LOADUSE));
    idleStep(1'b0, 1'b0, 1'b0); checkOutput("lu_cleared", 32'(ctl), 32'(NONE));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd9, 1'b0, 6'd9, 1'b1, 6'd9);
    checkOutput("lu_rt_p9", 32'(ctl), 32'(LOADUSE));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b1, 6'd0, 1'b0, 6'd0);
    checkOutput("lu_dest_p0", 32'(ctl), 32'(NONE));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0);
    checkOutput("lu_store", 32'(ctl), 32'(NONE));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0);
    checkOutput("lu_no_wb", 32'(ctl), 32'(NONE));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 6'd5, 1'b1, 6'd4);
    checkOutput("lu_rs_invalid", 32'(ctl), 32'(NONE));

    // Mispredict alone, then mispredict overriding a load-use
    idleStep(1'b0, 1'b0, 1'b1); checkOutput("misp_squash", 32'(ctl), 32'(SQUASH));
    idleStep(1'b0, 1'b0, 1'b0); checkOutput("misp_clear", 32'(ctl), 32'(NONE));
    checkOutput("misp_flush_cnt", 32'(flush_events), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd5, 1'b1, 6'd5, 1'b0, 6'd0);
    checkOutput("misp_over_lu", 32'(ctl), 32'(SQUASH));
    idleStep(1'b0, 1'b0, 1'b0);
    checkOutput("misp_flush_cnt2", 32'(flush_events), 2);

    // Mispredict deferred behind a memory hold
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("dm_idle_hold", 32'(ctl), 32'(HOLD_IDLE));
    idleStep(1'b1, 1'b0, 1'b1); checkOutput("dm_wait_misp", 32'(ctl), 32'(HOLD_WAIT));
    idleStep(1'b1, 1'b1, 1'b1); checkOutput("dm_wait_ack", 32'(ctl), 32'(HOLD_WAIT));
    checkOutput("dm_no_flush_yet", 32'(flush_events), 2);
    idleStep(1'b1, 1'b0, 1'b1); checkOutput("dm_done_squash", 32'(ctl), 32'(SQUASH));
    idleStep(1'b0, 1'b0, 1'b0); checkOutput("dm_after", 32'(ctl), 32'(NONE));
    checkOutput("dm_flush_cnt", 32'(flush_events), 3);
    checkOutput("dm_stall_cnt", 32'(stall_cycles), 7);

    // Back-to-back loads acked on first WAIT cycle
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("bb_idle1", 32'(ctl), 32'(HOLD_IDLE));
    idleStep(1'b1, 1'b1, 1'b0); checkOutput("bb_wait1", 32'(ctl), 32'(HOLD_WAIT));
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("bb_done1", 32'(ctl), 32'(NONE));
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("bb_idle2", 32'(ctl), 32'(HOLD_IDLE));
    idleStep(1'b1, 1'b1, 1'b0); checkOutput("bb_wait2", 32'(ctl), 32'(HOLD_WAIT));
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("bb_done2", 32'(ctl), 32'(NONE));
    idleStep(1'b0, 1'b1, 1'b0); checkOutput("ack_in_idle", 32'(ctl), 32'(NONE));
    idleStep(1'b0, 1'b0, 1'b0); checkOutput("ack_ignored", 32'(ctl), 32'(NONE));
    checkOutput("bb_stall_cnt", 32'(stall_cycles), 11);

    // Long wait saturates stall counter, then reset mid-WAIT
    idleStep(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) idleStep(1'b1, 1'b0, 1'b0);
    checkOutput("sat_wait_ctl", 32'(ctl), 32'(HOLD_WAIT));
    checkOutput("sat_stall_cnt", 32'(stall_cycles), 15);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_wait_ctl", 32'(ctl), 32'(HOLD_WAIT));
    @(negedge clk);
    rst_n = 1'b1;
    mem_enable = 1'b0;
    #1;
    checkOutput("rst_req_drop", 32'(ctl), 32'(NONE));
    checkOutput("rst_stall_cnt", 32'(stall_cycles), 0);
    checkOutput("rst_flush_cnt", 32'(flush_events), 0);
    idleStep(1'b1, 1'b0, 1'b0); checkOutput("rst_state_idle", 32'(ctl), 32'(HOLD_IDLE));
    idleStep(1'b1, 1'b1, 1'b0);
    idleStep(1'b0, 1'b0, 1'b0);

    // Flush counter saturation
    for (int i = 0; i < 17; i++) idleStep(1'b0, 1'b0, 1'b1);
    checkOutput("sat_flush_ctl", 32'(ctl), 32'(SQUASH));
    idleStep(1'b0, 1'b0, 1'b0);
    checkOutput("sat_flush_cnt", 32'(flush_events), 15);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
